// File: rtl/rgb_pwm_driver.sv
// Three-channel PWM driver for the RGB LED with per-channel shadowed duty registers.
// Define RGB_PHASE_STAGGER_EN to offset green/blue phases by 1/3 and 2/3 of a period.
module rgb_pwm_driver #(
    parameter int PWM_INTERVAL = 1200,
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int W            = $clog2(PWM_INTERVAL)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] r_pwm,
    input  logic [W-1:0] g_pwm,
    input  logic [W-1:0] b_pwm,
    output logic         red,
    output logic         green,
    output logic         blue,
    output logic         period_start
);

    localparam logic [W-1:0] LAST   = W'(PWM_INTERVAL - 1);
    localparam logic [W-1:0] FULL   = W'(PWM_INTERVAL);
    localparam logic [W:0]   FULL_X = (W+1)'(PWM_INTERVAL);

    logic [W-1:0]       cnt_q, cnt_d;
    logic [2:0][W-1:0]  duty_q, duty_d;
    logic [2:0][W-1:0]  ph;
    logic [2:0][W-1:0]  req;
    logic [2:0]         pin_q, pin_d;
    logic               period_start_q, period_start_d;

    function automatic logic [W-1:0] clamp_duty(input logic [W-1:0] v);
        return ({1'b0, v} > FULL_X) ? FULL : v;
    endfunction

`ifdef RGB_PHASE_STAGGER_EN
    function automatic logic [W-1:0] offset_phase(input logic [W-1:0] c, input int off);
        logic [W:0] s;
        s = {1'b0, c} + (W+1)'(off);
        if (s >= FULL_X) begin
            s = s - FULL_X;
        end
        return s[W-1:0];
    endfunction
`endif

    always_comb begin
        cnt_d          = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
        period_start_d = (cnt_q == '0);
        req[0]         = r_pwm;
        req[1]         = g_pwm;
        req[2]         = b_pwm;
`ifdef RGB_PHASE_STAGGER_EN
        ph[0] = cnt_q;
        ph[1] = offset_phase(cnt_q, PWM_INTERVAL / 3);
        ph[2] = offset_phase(cnt_q, (2 * PWM_INTERVAL) / 3);
`else
        ph[0] = cnt_q;
        ph[1] = cnt_q;
        ph[2] = cnt_q;
`endif
        duty_d = duty_q;
        pin_d  = {3{ACTIVE_LOW}};
        // Shadow loads on the last phase slot so a pulse is never cut or stretched.
        for (int i = 0; i < 3; i++) begin
            if (ph[i] == LAST) begin
                duty_d[i] = clamp_duty(req[i]);
            end
            pin_d[i] = (ph[i] < duty_q[i]) ^ ACTIVE_LOW;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            duty_q         <= '0;
            pin_q          <= {3{ACTIVE_LOW}};
            period_start_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            duty_q         <= duty_d;
            pin_q          <= pin_d;
            period_start_q <= period_start_d;
        end
    end

    assign red          = pin_q[0];
    assign green        = pin_q[1];
    assign blue         = pin_q[2];
    assign period_start = period_start_q;

endmodule
